if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 165 ++++++++++++++++
 tb/tb_if_fetch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding word
// request at a time, buffers responses in a 2-entry FIFO and flushes on redirect.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        br_ctrl_jump_en,
    input  logic [31:0] jump_pc,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    output logic        if_de_valid,
    output logic [31:0] if_de_inst,
    output logic [31:0] if_de_pc,
    input  logic        de_if_ready
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   next_pc_q, next_pc_d;
    logic [XLEN-1:0]   addr_d;
    logic              stale_q, stale_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   head_pc_d, head_inst_d;
    logic [XLEN-1:0]   tail_pc_q, tail_inst_q;
    logic [XLEN-1:0]   tail_pc_d, tail_inst_d;
    logic              req_d, valid_d;
    logic [XLEN-1:0]   target;
    logic              pop, resp, push, slot_free;

    // Word-aligned redirect target; the low bits of jump_pc are masked off.
    assign target = jump_pc & XLEN'(32'hFFFF_FFFC);

    // Handshake decodes; a redirect swallows any same-cycle push.
    assign pop  = if_de_valid & de_if_ready;
    assign resp = (state_q == S_WAIT) & ibus_rvalid;
    assign push = resp & ~stale_q & ~br_ctrl_jump_en;

    // Next-state, FIFO and fetch-PC logic.
    always_comb begin
        state_d     = state_q;
        next_pc_d   = next_pc_q;
        addr_d      = ibus_addr;
        stale_d     = stale_q;
        count_d     = count_q;
        head_pc_d   = if_de_pc;
        head_inst_d = if_de_inst;
        tail_pc_d   = tail_pc_q;
        tail_inst_d = tail_inst_q;
        req_d       = 1'b0;
        valid_d     = 1'b0;
        slot_free   = 1'b0;

        // FIFO: head lives in the output registers, tail behind it.
        if (br_ctrl_jump_en) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == '0) begin
                        head_pc_d   = ibus_addr;
                        head_inst_d = ibus_rdata;
                    end else begin
                        tail_pc_d   = ibus_addr;
                        tail_inst_d = ibus_rdata;
                    end
                    count_d = CNT_W'(count_q + CNT_W'(1));
                end
                2'b01: begin
                    head_pc_d   = tail_pc_q;
                    head_inst_d = tail_inst_q;
                    count_d     = CNT_W'(count_q - CNT_W'(1));
                end
                2'b11: begin
                    if (count_q == CNT_W'(1)) begin
                        head_pc_d   = ibus_addr;
                        head_inst_d = ibus_rdata;
                    end else begin
                        head_pc_d   = tail_pc_q;
                        head_inst_d = tail_inst_q;
                        tail_pc_d   = ibus_addr;
                        tail_inst_d = ibus_rdata;
                    end
                end
                default: ;
            endcase
        end

        // A new request only goes out when its response is guaranteed a slot.
        slot_free = (count_d <= CNT_W'(1));

        case (state_q)
            S_IDLE:  if (slot_free) state_d = S_REQ;
            S_REQ:   if (ibus_gnt) state_d = S_WAIT;
            S_WAIT:  if (ibus_rvalid) state_d = slot_free ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Address is captured on entry to REQ and held until grant.
        if ((state_d == S_REQ) && (state_q != S_REQ)) begin
            addr_d = br_ctrl_jump_en ? target : next_pc_q;
        end

        if (br_ctrl_jump_en) begin
            next_pc_d = target;
        end else if ((state_q == S_REQ) && ibus_gnt && !stale_q) begin
            next_pc_d = ibus_addr + XLEN'(32'd4);
        end

        // Mark the in-flight request stale; a response completing now leaves none.
        if (br_ctrl_jump_en) begin
            case (state_q)
                S_REQ:   stale_d = 1'b1;
                S_WAIT:  stale_d = ~ibus_rvalid;
                default: stale_d = stale_q;
            endcase
        end else if (resp) begin
            stale_d = 1'b0;
        end

        req_d   = (state_d == S_REQ);
        valid_d = (count_d != '0);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            next_pc_q   <= RESET_PC;
            stale_q     <= 1'b0;
            count_q     <= '0;
            ibus_req    <= 1'b0;
            ibus_addr   <= '0;
            if_de_valid <= 1'b0;
            if_de_pc    <= '0;
            if_de_inst  <= '0;
            tail_pc_q   <= '0;
            tail_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            next_pc_q   <= next_pc_d;
            stale_q     <= stale_d;
            count_q     <= count_d;
            ibus_req    <= req_d;
            ibus_addr   <= addr_d;
            if_de_valid <= valid_d;
            if_de_pc    <= head_pc_d;
            if_de_inst  <= head_inst_d;
            tail_pc_q   <= tail_pc_d;
            tail_inst_q <= tail_inst_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: bus responders return addr ^ 32'hA5A5_0000.
module tb_if_fetch;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_pc = '0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt = 1'b0;
    logic        ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic        if_de_valid;
    logic [31:0] if_de_inst;
    logic [31:0] if_de_pc;
    logic        de_if_ready = 1'b1;

    logic        rstn2 = 1'b0;
    logic        ibus_req2;
    logic [31:0] ibus_addr2;
    logic        ibus_gnt2 = 1'b0;
    logic        ibus_rvalid2 = 1'b0;
    logic [31:0] ibus_rdata2 = '0;
    logic        if_de_valid2;
    logic [31:0] if_de_inst2;
    logic [31:0] if_de_pc2;

    logic        gnt_en = 1'b1;
    logic        rsp_en = 1'b1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        pend2 = 1'b0;
    logic [31:0] pend_addr2 = '0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic [63:0] dec_q[$];
    int          dec_cyc[$];
    logic [63:0] dec2_q[$];
    logic [31:0] gnt_log[$];

    if_fetch u_dut (
        .clk(clk), .rstn(rstn),
        .br_ctrl_jump_en(jump_en), .jump_pc(jump_pc),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
        .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
        .if_de_valid(if_de_valid), .if_de_inst(if_de_inst), .if_de_pc(if_de_pc),
        .de_if_ready(de_if_ready)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk(clk), .rstn(rstn2),
        .br_ctrl_jump_en(1'b0), .jump_pc(32'h0),
        .ibus_req(ibus_req2), .ibus_addr(ibus_addr2), .ibus_gnt(ibus_gnt2),
        .ibus_rvalid(ibus_rvalid2), .ibus_rdata(ibus_rdata2),
        .if_de_valid(if_de_valid2), .if_de_inst(if_de_inst2), .if_de_pc(if_de_pc2),
        .de_if_ready(1'b1)
    );

    always #5 clk = ~clk;

    // Cycle counter for cadence measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder for u_dut: grant same cycle, respond the cycle after.
    always begin
        @(posedge clk);
        #1;
        ibus_gnt    = 1'b0;
        ibus_rvalid = 1'b0;
        if (!rstn) begin
            pend = 1'b0;
        end else begin
            if (pend && rsp_en) begin
                ibus_rvalid = 1'b1;
                ibus_rdata  = pend_addr ^ K;
                pend        = 1'b0;
            end
            if (ibus_req && gnt_en && !pend) begin
                ibus_gnt  = 1'b1;
                pend      = 1'b1;
                pend_addr = ibus_addr;
                gnt_log.push_back(ibus_addr);
            end
        end
    end

    // Bus responder for u_dut2, always zero-wait.
    always begin
        @(posedge clk);
        #1;
        ibus_gnt2    = 1'b0;
        ibus_rvalid2 = 1'b0;
        if (!rstn2) begin
            pend2 = 1'b0;
        end else begin
            if (pend2) begin
                ibus_rvalid2 = 1'b1;
                ibus_rdata2  = pend_addr2 ^ K;
                pend2        = 1'b0;
            end
            if (ibus_req2 && !pend2) begin
                ibus_gnt2  = 1'b1;
                pend2      = 1'b1;
                pend_addr2 = ibus_addr2;
            end
        end
    end

    // Decode-side monitors: record each accepted head.
    always @(negedge clk) begin
        if (rstn && if_de_valid && de_if_ready) begin
            dec_q.push_back({if_de_pc, if_de_inst});
            dec_cyc.push_back(cyc);
        end
        if (rstn2 && if_de_valid2) dec2_q.push_back({if_de_pc2, if_de_inst2});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int qsize(input bit sel);
        return sel ? dec2_q.size() : dec_q.size();
    endfunction

    task automatic wait_entries(input bit sel, input int n, input string tag);
        for (int i = 0; i < 80 && qsize(sel) < n; i++) tick();
        chk({tag, "_count"}, 32'(qsize(sel) >= n), 32'd1);
    endtask

    task automatic expect_entry(input bit sel, input string tag, input int idx, input logic [31:0] pc);
        logic [63:0] e;
        if (idx < qsize(sel)) begin
            e = sel ? dec2_q[idx] : dec_q[idx];
            chk({tag, "_pc"}, e[63:32], pc);
            chk({tag, "_inst"}, e[31:0], pc ^ K);
        end else begin
            chk({tag, "_missing"}, 32'(qsize(sel)), 32'(idx + 1));
        end
    endtask

    task automatic do_reset(input logic rdy);
        rstn        = 1'b0;
        jump_en     = 1'b0;
        de_if_ready = rdy;
        gnt_en      = 1'b1;
        rsp_en      = 1'b1;
        repeat (2) tick();
        dec_q.delete();
        dec_cyc.delete();
        gnt_log.delete();
        rstn = 1'b1;
    endtask

    initial begin
        bit found;
        bit req_seen;

        // Reset state and first request timing.
        repeat (3) tick();
        chk("rst_req", 32'(ibus_req), 32'd0);
        chk("rst_addr", ibus_addr, 32'd0);
        chk("rst_valid", 32'(if_de_valid), 32'd0);
        chk("rst_inst", if_de_inst, 32'd0);
        chk("rst_pc", if_de_pc, 32'd0);
        rstn = 1'b1;
        chk("rel_req_pre", 32'(ibus_req), 32'd0);
        tick();
        chk("rel_req_first", 32'(ibus_req), 32'd1);
        chk("rel_addr_first", ibus_addr, 32'h0);
        wait_entries(1'b0, 3, "t1");
        expect_entry(1'b0, "t1_e0", 0, 32'h0);
        expect_entry(1'b0, "t1_e1", 1, 32'h4);
        expect_entry(1'b0, "t1_e2", 2, 32'h8);
        if (dec_cyc.size() >= 3) begin
            chk("t1_gap01", 32'((dec_cyc[1] - dec_cyc[0]) <= 3), 32'd1);
            chk("t1_gap12", 32'((dec_cyc[2] - dec_cyc[1]) <= 3), 32'd1);
        end

        // Decode stall with FIFO full.
        do_reset(1'b0);
        repeat (10) tick();
        req_seen = 1'b0;
        repeat (10) begin
            tick();
            if (ibus_req) req_seen = 1'b1;
        end
        chk("t2_stall_req", 32'(req_seen), 32'd0);
        chk("t2_valid", 32'(if_de_valid), 32'd1);
        chk("t2_head_pc", if_de_pc, 32'h0);
        chk("t2_head_inst", if_de_inst, 32'hA5A5_0000);
        chk("t2_no_pop", 32'(dec_q.size()), 32'd0);
        de_if_ready = 1'b1;
        wait_entries(1'b0, 3, "t2");
        expect_entry(1'b0, "t2_e0", 0, 32'h0);
        expect_entry(1'b0, "t2_e1", 1, 32'h4);
        expect_entry(1'b0, "t2_e2", 2, 32'h8);

        // Redirect while waiting for the response of addr 8.
        do_reset(1'b1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (ibus_req && ibus_gnt && ibus_addr == 32'h8) found = 1'b1;
        end
        chk("t3_reach", 32'(found), 32'd1);
        rsp_en = 1'b0;
        tick();
        jump_en = 1'b1;
        jump_pc = 32'h0000_1002;
        tick();
        jump_en = 1'b0;
        dec_q.delete();
        chk("t3_valid_flush", 32'(if_de_valid), 32'd0);
        chk("t3_req_held", 32'(ibus_req), 32'd0);
        rsp_en = 1'b1;
        for (int i = 0; i < 10 && !ibus_req; i++) tick();
        chk("t3_target_addr", ibus_addr, 32'h0000_1000);
        wait_entries(1'b0, 2, "t3");
        expect_entry(1'b0, "t3_e0", 0, 32'h0000_1000);
        expect_entry(1'b0, "t3_e1", 1, 32'h0000_1004);

        // Redirect on grant, then a second redirect before the response.
        do_reset(1'b1);
        rsp_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (ibus_req && ibus_gnt) found = 1'b1;
        end
        chk("t4_reach", 32'(found), 32'd1);
        jump_en = 1'b1;
        jump_pc = 32'h0000_2000;
        tick();
        jump_pc = 32'h0000_3000;
        tick();
        jump_en = 1'b0;
        rsp_en  = 1'b1;
        dec_q.delete();
        wait_entries(1'b0, 2, "t4");
        expect_entry(1'b0, "t4_e0", 0, 32'h0000_3000);
        expect_entry(1'b0, "t4_e1", 1, 32'h0000_3004);
        chk("t4_grants", 32'(gnt_log.size() >= 2), 32'd1);
        if (gnt_log.size() >= 2) chk("t4_second_grant", gnt_log[1], 32'h0000_3000);

        // Redirect coinciding with a live response and a pop.
        do_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (ibus_req && ibus_gnt && ibus_addr == 32'h4) found = 1'b1;
        end
        chk("t5_reach", 32'(found), 32'd1);
        chk("t5_one_buffered", 32'(if_de_valid), 32'd1);
        rsp_en = 1'b0;
        tick();
        rsp_en = 1'b1;
        tick();
        chk("t5_rvalid_now", 32'(ibus_rvalid), 32'd1);
        jump_en     = 1'b1;
        jump_pc     = 32'h0000_4000;
        de_if_ready = 1'b1;
        tick();
        jump_en = 1'b0;
        dec_q.delete();
        chk("t5_valid_flush", 32'(if_de_valid), 32'd0);
        chk("t5_req", 32'(ibus_req), 32'd1);
        chk("t5_addr", ibus_addr, 32'h0000_4000);
        wait_entries(1'b0, 1, "t5");
        expect_entry(1'b0, "t5_e0", 0, 32'h0000_4000);

        // Non-zero reset PC with address wrap, then reset mid-transaction.
        rstn2 = 1'b1;
        wait_entries(1'b1, 3, "t6");
        expect_entry(1'b1, "t6_e0", 0, 32'hFFFF_FFF8);
        expect_entry(1'b1, "t6_e1", 1, 32'hFFFF_FFFC);
        expect_entry(1'b1, "t6_e2", 2, 32'h0000_0000);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (ibus_req2 && ibus_gnt2 && ibus_addr2 == 32'h8) found = 1'b1;
        end
        chk("t6_reach", 32'(found), 32'd1);
        tick();
        chk("t6_pre_addr", ibus_addr2, 32'h8);
        rstn2 = 1'b0;
        #1;
        chk("t6_rst_req", 32'(ibus_req2), 32'd0);
        chk("t6_rst_addr", ibus_addr2, 32'd0);
        chk("t6_rst_valid", 32'(if_de_valid2), 32'd0);
        chk("t6_rst_inst", if_de_inst2, 32'd0);
        chk("t6_rst_pc", if_de_pc2, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
